// File: rtl/multi_lane_hit_accumulator.sv
// rtl/multi_lane_hit_accumulator.sv - multi-lane Monte-Carlo hit/sample accumulator with valid/ready result
//
// Purpose: counts hit flags and samples from NUM_LANES parallel point generators
// until a latched sample target is reached or the batch is aborted, then holds
// the (hits, samples, aborted) result until the consumer accepts it.
//
// Ports:
//   clk, reset        clock and synchronous active-high reset
//   start             begin a batch (accepted only in IDLE); latches target
//   abort             end a running batch early, keeping partial counts
//   target            samples per batch
//   din_valid, din    per-lane sample valid and hit flag
//   hits, samples     accumulated counts (registered)
//   result_valid      result available (HOLD)
//   result_ready      consumer accepts result
//   busy              batch running (RUN)
//   aborted           result came from an aborted batch
module multi_lane_hit_accumulator #(
    parameter int NUM_LANES = 4,
    parameter int COUNT_W   = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 abort,
    input  logic [COUNT_W-1:0]   target,
    input  logic [NUM_LANES-1:0] din_valid,
    input  logic [NUM_LANES-1:0] din,
    output logic [COUNT_W-1:0]   hits,
    output logic [COUNT_W-1:0]   samples,
    output logic                 result_valid,
    input  logic                 result_ready,
    output logic                 busy,
    output logic                 aborted
);

    localparam int PC_W = $clog2(NUM_LANES + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [COUNT_W-1:0] target_q, target_d;
    logic [COUNT_W-1:0] hits_q, hits_d;
    logic [COUNT_W-1:0] samples_q, samples_d;
    logic               aborted_q, aborted_d;
    logic               busy_q, busy_d;
    logic               result_valid_q, result_valid_d;

    logic [COUNT_W-1:0] remaining;
    logic [PC_W-1:0]    acc_cnt;
    logic [PC_W-1:0]    hit_cnt;

    // Lanes are granted in index order until the remaining sample budget is
    // used up; later valid lanes in the final beat are dropped.
    always_comb begin
        remaining = target_q - samples_q;
        acc_cnt   = '0;
        hit_cnt   = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (din_valid[i] && (COUNT_W'(acc_cnt) < remaining)) begin
                acc_cnt = acc_cnt + PC_W'(1);
                if (din[i]) begin
                    hit_cnt = hit_cnt + PC_W'(1);
                end
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        target_d  = target_q;
        hits_d    = hits_q;
        samples_d = samples_q;
        aborted_d = aborted_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    target_d  = target;
                    hits_d    = '0;
                    samples_d = '0;
                    aborted_d = 1'b0;
                    state_d   = (target != '0) ? RUN : HOLD;
                end
            end
            RUN: begin
                samples_d = samples_q + COUNT_W'(acc_cnt);
                hits_d    = hits_q + COUNT_W'(hit_cnt);
                // Completion wins over a coincident abort.
                if (samples_d == target_q) begin
                    state_d = HOLD;
                end else if (abort) begin
                    state_d   = HOLD;
                    aborted_d = 1'b1;
                end
            end
            HOLD: begin
                if (result_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d         = (state_d == RUN);
        result_valid_d = (state_d == HOLD);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            target_q       <= '0;
            hits_q         <= '0;
            samples_q      <= '0;
            aborted_q      <= 1'b0;
            busy_q         <= 1'b0;
            result_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            target_q       <= target_d;
            hits_q         <= hits_d;
            samples_q      <= samples_d;
            aborted_q      <= aborted_d;
            busy_q         <= busy_d;
            result_valid_q <= result_valid_d;
        end
    end

    assign hits         = hits_q;
    assign samples      = samples_q;
    assign aborted      = aborted_q;
    assign busy         = busy_q;
    assign result_valid = result_valid_q;

endmodule

// File: tb/tb_multi_lane_hit_accumulator.sv
// tb/tb_multi_lane_hit_accumulator.sv - self-checking bench for multi_lane_hit_accumulator
module tb_multi_lane_hit_accumulator;

    localparam int NL = 4;
    localparam int CW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          abort;
    logic [CW-1:0] target;
    logic [NL-1:0] din_valid;
    logic [NL-1:0] din;
    logic [CW-1:0] hits;
    logic [CW-1:0] samples;
    logic          result_valid;
    logic          result_ready;
    logic          busy;
    logic          aborted;

    multi_lane_hit_accumulator #(.NUM_LANES(NL), .COUNT_W(CW)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .abort(abort),
        .target(target),
        .din_valid(din_valid),
        .din(din),
        .hits(hits),
        .samples(samples),
        .result_valid(result_valid),
        .result_ready(result_ready),
        .busy(busy),
        .aborted(aborted)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Reference model: phase 0=idle, 1=running, 2=holding result
    int          m_phase = 0;
    longint      m_target = 0;
    longint      m_hits = 0;
    longint      m_samples = 0;
    bit          m_aborted = 0;

    typedef struct {
        logic          start;
        logic          abort;
        logic          ready;
        logic [CW-1:0] target;
        logic [NL-1:0] dv;
        logic [NL-1:0] din;
        logic [CW-1:0] e_hits;
        logic [CW-1:0] e_samples;
        logic          e_rv;
        logic          e_busy;
        logic          e_ab;
    } vec_t;

    vec_t vecs[25];

    function automatic vec_t mk(int st, int ab, int rdy, int tgt, int dv, int dn,
                                int eh, int es, int erv, int eb, int ea);
        vec_t v;
        v.start     = (st != 0);
        v.abort     = (ab != 0);
        v.ready     = (rdy != 0);
        v.target    = tgt;
        v.dv        = NL'(dv);
        v.din       = NL'(dn);
        v.e_hits    = eh;
        v.e_samples = es;
        v.e_rv      = (erv != 0);
        v.e_busy    = (eb != 0);
        v.e_ab      = (ea != 0);
        return v;
    endfunction

    task automatic check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Apply the spec's rules to the inputs present at the coming edge.
    task automatic model_step();
        int q[$];
        longint rem;
        int take;
        if (reset) begin
            m_phase = 0; m_target = 0; m_hits = 0; m_samples = 0; m_aborted = 0;
            return;
        end
        case (m_phase)
            0: if (start) begin
                m_target = target; m_hits = 0; m_samples = 0; m_aborted = 0;
                m_phase = (target != 0) ? 1 : 2;
            end
            1: begin
                rem = m_target - m_samples;
                for (int i = 0; i < NL; i++) if (din_valid[i]) q.push_back(i);
                take = (q.size() < rem) ? q.size() : int'(rem);
                for (int k = 0; k < take; k++) m_hits += din[q[k]];
                m_samples += take;
                if (m_samples == m_target) m_phase = 2;
                else if (abort) begin m_phase = 2; m_aborted = 1; end
            end
            default: if (result_ready) m_phase = 0;
        endcase
    endtask

    task automatic cyc();
        model_step();
        @(posedge clk);
        #1;
        check("model hits", hits, CW'(m_hits));
        check("model samples", samples, CW'(m_samples));
        check("model result_valid", CW'(result_valid), CW'(m_phase == 2));
        check("model busy", CW'(busy), CW'(m_phase == 1));
        check("model aborted", CW'(aborted), CW'(m_aborted));
    endtask

    task automatic idle_in();
        reset = 0; start = 0; abort = 0; result_ready = 0;
        target = '0; din_valid = '0; din = '0;
    endtask

    task automatic expect_out(input string tag, input int eh, input int es,
                              input int erv, input int eb, input int ea);
        check({tag, " hits"}, hits, CW'(eh));
        check({tag, " samples"}, samples, CW'(es));
        check({tag, " result_valid"}, CW'(result_valid), CW'(erv));
        check({tag, " busy"}, CW'(busy), CW'(eb));
        check({tag, " aborted"}, CW'(aborted), CW'(ea));
    endtask

    initial begin
        vecs[0]  = mk(1,0,0,  8,  0,  0, 0, 0,0,1,0);
        vecs[1]  = mk(0,0,0,  8,'hF,'hA, 2, 4,0,1,0);
        vecs[2]  = mk(0,0,0,  8,'hF,'hF, 6, 8,1,0,0);
        vecs[3]  = mk(0,0,0,  0,  0,  0, 6, 8,1,0,0);
        vecs[4]  = mk(0,0,1,  0,  0,  0, 6, 8,0,0,0);
        vecs[5]  = mk(1,0,0,  6,  0,  0, 0, 0,0,1,0);
        vecs[6]  = mk(0,0,0,  0,'hF,'h1, 1, 4,0,1,0);
        vecs[7]  = mk(0,0,0,  0,'hF,'hE, 2, 6,1,0,0);
        vecs[8]  = mk(0,0,1,  0,  0,  0, 2, 6,0,0,0);
        vecs[9]  = mk(1,0,0,  0,  0,  0, 0, 0,1,0,0);
        vecs[10] = mk(1,0,1,  5,  0,  0, 0, 0,0,0,0);
        vecs[11] = mk(0,0,0,  0,  0,  0, 0, 0,0,0,0);
        vecs[12] = mk(1,0,0,100,  0,  0, 0, 0,0,1,0);
        vecs[13] = mk(0,0,0,  0,'hF,'hF, 4, 4,0,1,0);
        vecs[14] = mk(0,0,0,  0,'hF,'hF, 8, 8,0,1,0);
        vecs[15] = mk(0,1,0,  0,'hF,  0, 8,12,1,0,1);
        vecs[16] = mk(0,0,1,  0,  0,  0, 8,12,0,0,1);
        vecs[17] = mk(1,0,0,  4,  0,  0, 0, 0,0,1,0);
        vecs[18] = mk(0,1,0,  0,'hF,'h3, 2, 4,1,0,0);
        vecs[19] = mk(0,0,1,  0,  0,  0, 2, 4,0,0,0);
        vecs[20] = mk(1,0,0,  8,  0,  0, 0, 0,0,1,0);
        vecs[21] = mk(1,0,0,  2,'hF,'hF, 4, 4,0,1,0);
        vecs[22] = mk(0,0,0,  0,'hF,  0, 4, 8,1,0,0);
        vecs[23] = mk(1,0,0,  0,  0,  0, 4, 8,1,0,0);
        vecs[24] = mk(0,0,1,  0,  0,  0, 4, 8,0,0,0);

        idle_in();
        reset = 1;
        cyc();
        cyc();
        expect_out("reset", 0, 0, 0, 0, 0);
        reset = 0;

        for (int r = 0; r < 25; r++) begin
            start = vecs[r].start; abort = vecs[r].abort; result_ready = vecs[r].ready;
            target = vecs[r].target; din_valid = vecs[r].dv; din = vecs[r].din;
            cyc();
            expect_out($sformatf("vec%0d", r), int'(vecs[r].e_hits), int'(vecs[r].e_samples),
                       int'(vecs[r].e_rv), int'(vecs[r].e_busy), int'(vecs[r].e_ab));
        end

        // Sparse valids and result backpressure
        idle_in(); start = 1; target = 3; cyc();
        idle_in(); din_valid = 4'b0100; din = 4'hF; cyc();
        expect_out("sparse b1", 1, 1, 0, 1, 0);
        din_valid = 4'b0000; cyc();
        expect_out("sparse b2", 1, 1, 0, 1, 0);
        din_valid = 4'b1001; cyc();
        expect_out("sparse b3", 3, 3, 1, 0, 0);
        idle_in();
        for (int k = 0; k < 5; k++) begin
            din_valid = 4'hF; din = 4'hF; start = 1; abort = 1;
            cyc();
            expect_out($sformatf("stall%0d", k), 3, 3, 1, 0, 0);
        end
        idle_in(); result_ready = 1; cyc();
        expect_out("sparse ready", 3, 3, 0, 0, 0);
        idle_in(); cyc();
        expect_out("sparse idle", 3, 3, 0, 0, 0);

        // Reset in the middle of a batch
        start = 1; target = 10; cyc();
        idle_in(); din_valid = 4'hF; din = 4'h1; cyc();
        expect_out("pre-reset", 1, 4, 0, 1, 0);
        idle_in(); reset = 1; din_valid = 4'hF; cyc();
        expect_out("mid reset", 0, 0, 0, 0, 0);
        idle_in(); start = 1; target = 4; cyc();
        idle_in(); din_valid = 4'hF; din = 4'h5; cyc();
        expect_out("post-reset", 2, 4, 1, 0, 0);
        idle_in(); result_ready = 1; cyc();

        // Randomized traffic against the model
        for (int n = 0; n < 500; n++) begin
            reset        = ($urandom_range(0, 99) == 0);
            start        = ($urandom_range(0, 3) == 0);
            abort        = ($urandom_range(0, 19) == 0);
            result_ready = ($urandom_range(0, 2) != 0);
            target       = CW'($urandom_range(0, 20));
            din_valid    = NL'($urandom);
            din          = NL'($urandom);
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/multi_lane_hit_accumulator.md
Name: multi_lane_hit_accumulator

Overview:
- Parametrised successor to the single-lane hit counter in the Pi estimator datapath.
- Accepts up to NUM_LANES Monte-Carlo hit/miss results per cycle from parallel point generators.
- Counts hits and samples against a programmable sample target, and supports abort.
- Presents the final (hits, samples) pair to the result consumer over a valid/ready handshake.

Parameters:
NUM_LANES, 4, number of parallel sample lanes (1..16)
COUNT_W, 32, width of target, hit and sample counters

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high; clears all state
start  input  1  pulse; begins a batch when in IDLE
abort  input  1  ends a running batch early with partial counts
target  input  COUNT_W  number of samples in batch; latched on accepted start
din_valid  input  NUM_LANES  per-lane sample valid
din  input  NUM_LANES  per-lane hit flag (1 = inside circle); ignored where din_valid=0
hits  output  COUNT_W  accumulated hit count
samples  output  COUNT_W  accumulated sample count
result_valid  output  1  final result available
result_ready  input  1  consumer accepts result
busy  output  1  high in RUN
aborted  output  1  result came from an aborted batch; valid with result_valid

Behaviour:
- Reset is on clk; reset is synchronous, active-high.
- Reset values: hits=0, samples=0, result_valid=0, busy=0, aborted=0; state IDLE. Reset overrides every other input, including mid-batch or mid-handshake.
- States are IDLE, RUN, HOLD.
- IDLE:
  - start=1 -> latch target; clear hits, samples and aborted.
  - If target!=0, go to RUN next cycle.
  - If target==0, go to HOLD (result 0/0).
  - din is ignored in IDLE.
- RUN:
  - busy=1.
  - remaining = target_latched - samples.
  - Accept mask: scan lanes in index order, 0 first. A lane is accepted if din_valid[i]=1 and fewer than remaining lanes have been accepted so far. Excess valid lanes in the final cycle are dropped silently.
  - Update: samples += popcount(mask); hits += popcount(mask & din). Both update in the same cycle.
  - If samples+popcount(mask)==target_latched, go to HOLD next cycle. result_valid rises in the cycle after the last sample is accepted.
  - abort=1 -> go to HOLD and set aborted=1. Samples in the abort cycle are still counted, subject to the same mask rule. If abort coincides with completion, aborted=0.
  - start is ignored in RUN.
- HOLD:
  - result_valid=1; hits, samples and aborted are held stable.
  - result_ready=1 -> go to IDLE; result_valid falls next cycle. Counters keep their value until the next accepted start.
  - start and abort are ignored in HOLD. A start coincident with the ready handshake is not accepted; it must be reasserted in IDLE.
- Arithmetic:
  - Counters are unsigned COUNT_W.
  - Invariant: hits <= samples <= target_latched < 2^COUNT_W, so no overflow is possible.
  - popcount width is clog2(NUM_LANES+1), zero-extended.
- Result is registered. No combinational path from din to the outputs.
- Throughput: one batch per target/NUM_LANES cycles (rounded up), plus 1 cycle HOLD entry, plus the handshake wait.

Test Plan:
- Basic batch: NUM_LANES=4, target=8, two cycles of din_valid=4'b1111 with din=4'b1010 then 4'b1111 -> result_valid asserts 1 cycle after the second beat; hits=6, samples=8, aborted=0.
- Partial final beat: target=6, beats 4'b1111/din 4'b0001 then 4'b1111/din 4'b1110 -> only lanes 0,1 accepted in beat 2; samples=6, hits=2.
- Sparse valid and backpressure: target=3, din_valid 4'b0100, 4'b0000, 4'b1001, all din=1; hold result_ready=0 for 5 cycles -> samples=3, hits=3; result_valid and outputs stable 5 cycles; IDLE one cycle after ready.
- Abort: target=100, 2 beats of all-valid/all-hit, abort=1 on the 3rd beat (all-valid, din=0) -> samples=12, hits=8, aborted=1. Abort on the final completing beat -> aborted=0.
- Zero target and ignored start: target=0 start -> result_valid next cycle, 0/0. start pulsed during RUN and HOLD -> no effect on counts or target.
- Reset mid-batch: reset during RUN with samples=4 -> next cycle all outputs 0, IDLE. A following start with target=4 completes normally with samples=4.
